// File: rtl/prio_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// prio_arb_pkg
//
// Purpose : Shared definitions for the registered priority / round-robin
//           arbiter (prio_arbiter) and its combinational search core
//           (prio_pick).
//
// Contents:
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   arb_state_t          : two-state arbiter FSM (IDLE, GRANT)
//   idx_width(n)         : width of a channel index for n channels (>= 1)
// ---------------------------------------------------------------------------
package prio_arb_pkg;

  // Arbitration mode encodings, as seen on the 'mode' input.
  localparam logic MODE_FIXED = 1'b0;  // highest index wins
  localparam logic MODE_RR    = 1'b1;  // last winner drops to lowest priority

  // Arbiter FSM states.
  typedef enum logic {
    IDLE  = 1'b0,  // no grant outstanding; arbitrate every cycle
    GRANT = 1'b1   // grant frozen until ack
  } arb_state_t;

  // Number of bits needed to hold a channel index 0..n-1. Clamped to 1 so a
  // degenerate channel count still yields a legal vector width.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : prio_arb_pkg

// File: rtl/prio_arbiter_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
//
// Purpose : Purely combinational winner search shared by both arbitration
//           modes. Searches downward starting at ptr-1, wrapping from 0 to
//           N-1, with channel 'ptr' itself examined last. With rr_en=0 (or
//           ptr=0) the search starts at N-1, i.e. plain highest-index-wins.
//
// Parameters:
//   N      number of request channels (2..64)
//   IDX_W  derived index width, not to be overridden
//
// Ports:
//   req    [N-1:0]      in   request vector (already masked by the caller)
//   ptr    [IDX_W-1:0]  in   round-robin pointer (last winner)
//   rr_en               in   1 = round-robin search, 0 = fixed priority
//   found               out  at least one request present
//   win    [IDX_W-1:0]  out  winning channel index (0 when found=0)
// ---------------------------------------------------------------------------
module prio_pick
  import prio_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_en,
  output logic             found,
  output logic [IDX_W-1:0] win
);

  // The rotated downward search is realised without any modulo arithmetic:
  // the channels strictly below ptr are the ones visited first (ptr-1 down
  // to 0); only if none of them requests does the search continue from N-1
  // down to ptr. So: highest set bit among the "below ptr" requests, else
  // highest set bit of the whole vector. Because the second pass can only
  // hit bits >= ptr, the ptr channel naturally comes last. This stays
  // correct for any N, power of two or not.
  logic [N-1:0] low_mask;
  logic [N-1:0] low_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_low_mask
      assign low_mask[gi] = rr_en & (IDX_W'(gi) < ptr);
    end
  endgenerate

  assign low_req = req & low_mask;

  logic [IDX_W-1:0] low_idx;
  logic [IDX_W-1:0] all_idx;

  // Priority scan: later (higher) set bits overwrite earlier ones, leaving
  // the highest set index in each result.
  always_comb begin
    low_idx = '0;
    all_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (low_req[k]) begin
        low_idx = IDX_W'(k);
      end
      if (req[k]) begin
        all_idx = IDX_W'(k);
      end
    end
  end

  assign found = |req;
  assign win   = (|low_req) ? low_idx : all_idx;

endmodule : prio_pick

// File: rtl/prio_arbiter.sv
// ---------------------------------------------------------------------------
// prio_arbiter
//
// Purpose : Registered N-channel arbiter, the successor of the 8:3 priority
//           encoder. Arbitrates in IDLE, then holds a sticky grant in GRANT
//           until the consumer acknowledges it. Two run-time modes:
//             mode=0 fixed priority  - highest requesting index wins
//             mode=1 round-robin     - last acknowledged winner drops to
//                                      lowest priority
//           All outputs are registered; one cycle from req to gnt_valid,
//           and at least two cycles per grant (grant + ack, then a bubble
//           in IDLE before the next arbitration).
//
// Build option:
//   PRIO_ARBITER_REQ_MASK_EN  adds the req_mask input; masked channels are
//                             never granted. An outstanding grant is not
//                             revoked by masking its channel.
//
// Parameters:
//   N      number of request channels (2..64), default 8
//   IDX_W  derived index width, not to be overridden
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   req         in   N      request vector, bit k = channel k
//   req_mask    in   N      (option only) 1 = channel k ignored
//   mode        in   1      0 = fixed, 1 = round-robin; sampled in IDLE only
//   ack         in   1      consumer done with current grant (GRANT only)
//   gnt_idx     out  IDX_W  granted channel index (0 when no grant)
//   gnt_onehot  out  N      one-hot grant, 0 when no grant
//   gnt_valid   out  1      grant outstanding
// ---------------------------------------------------------------------------
module prio_arbiter
  import prio_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
`ifdef PRIO_ARBITER_REQ_MASK_EN
  input  logic [N-1:0]     req_mask,
`endif
  input  logic             mode,
  input  logic             ack,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic             gnt_valid
);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  arb_state_t       state_reg,      state_next;
  logic [IDX_W-1:0] gnt_idx_reg,    gnt_idx_next;
  logic [N-1:0]     gnt_onehot_reg, gnt_onehot_next;
  logic             gnt_valid_reg,  gnt_valid_next;
  logic [IDX_W-1:0] rr_ptr_reg,     rr_ptr_next;
  // Mode in force when the current grant was issued. The pointer update on
  // ack follows the mode the grant was made under, so toggling 'mode'
  // during GRANT only affects the next arbitration.
  logic             gnt_mode_reg,   gnt_mode_next;

  // -------------------------------------------------------------------------
  // Effective request vector
  // -------------------------------------------------------------------------
  logic [N-1:0] eff_req;

`ifdef PRIO_ARBITER_REQ_MASK_EN
  assign eff_req = req & ~req_mask;
`else
  assign eff_req = req;
`endif

  // -------------------------------------------------------------------------
  // Winner search
  // -------------------------------------------------------------------------
  logic             pick_rr_en;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;

  assign pick_rr_en = (mode == MODE_RR);

  prio_pick #(
    .N (N)
  ) u_pick (
    .req   (eff_req),
    .ptr   (rr_ptr_reg),
    .rr_en (pick_rr_en),
    .found (pick_found),
    .win   (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State register (also holds the registered outputs and rr pointer)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gnt_idx_reg    <= '0;
      gnt_onehot_reg <= '0;
      gnt_valid_reg  <= 1'b0;
      rr_ptr_reg     <= '0;
      gnt_mode_reg   <= MODE_FIXED;
    end else begin
      state_reg      <= state_next;
      gnt_idx_reg    <= gnt_idx_next;
      gnt_onehot_reg <= gnt_onehot_next;
      gnt_valid_reg  <= gnt_valid_next;
      rr_ptr_reg     <= rr_ptr_next;
      gnt_mode_reg   <= gnt_mode_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_idx_next    = gnt_idx_reg;
    gnt_onehot_next = gnt_onehot_reg;
    gnt_valid_next  = gnt_valid_reg;
    rr_ptr_next     = rr_ptr_reg;
    gnt_mode_next   = gnt_mode_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          gnt_idx_next    = pick_idx;
          gnt_onehot_next = pick_onehot;
          gnt_valid_next  = 1'b1;
          gnt_mode_next   = mode;
        end else begin
          gnt_idx_next    = '0;
          gnt_onehot_next = '0;
          gnt_valid_next  = 1'b0;
        end
      end
      GRANT: begin
        // Frozen apart from ack: req, mask and mode changes are ignored and
        // the grant survives its own request bit dropping.
        if (ack) begin
          gnt_idx_next    = '0;
          gnt_onehot_next = '0;
          gnt_valid_next  = 1'b0;
          if (gnt_mode_reg == MODE_RR) begin
            rr_ptr_next = gnt_idx_reg;
          end
        end
      end
      default: begin
        gnt_idx_next    = '0;
        gnt_onehot_next = '0;
        gnt_valid_next  = 1'b0;
      end
    endcase
  end

  assign gnt_idx    = gnt_idx_reg;
  assign gnt_onehot = gnt_onehot_reg;
  assign gnt_valid  = gnt_valid_reg;

endmodule : prio_arbiter

// File: tb/tb_prio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prio_arbiter
//
// Self-checking bench for prio_arbiter. Two instances share clock and
// reset: an N=8 arbiter and an N=5 arbiter for the non-power-of-2 wrap.
// Expected grant state is pushed into a scoreboard queue when stimulus is
// driven and popped after the following clock edge. Build with
// PRIO_ARBITER_REQ_MASK_EN defined to exercise the req_mask variant.
// ---------------------------------------------------------------------------
module tb_prio_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic [7:0] req8;
  logic       mode8;
  logic       ack8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic       v8;

  logic [4:0] req5;
  logic       mode5;
  logic       ack5;
  logic [2:0] idx5;
  logic [4:0] oh5;
  logic       v5;

`ifdef PRIO_ARBITER_REQ_MASK_EN
  logic [7:0] mask8;
  logic [4:0] mask5;
`endif

  prio_arbiter #(.N(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req8),
`ifdef PRIO_ARBITER_REQ_MASK_EN
    .req_mask   (mask8),
`endif
    .mode       (mode8),
    .ack        (ack8),
    .gnt_idx    (idx8),
    .gnt_onehot (oh8),
    .gnt_valid  (v8)
  );

  prio_arbiter #(.N(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req5),
`ifdef PRIO_ARBITER_REQ_MASK_EN
    .req_mask   (mask5),
`endif
    .mode       (mode5),
    .ack        (ack5),
    .gnt_idx    (idx5),
    .gnt_onehot (oh5),
    .gnt_valid  (v5)
  );

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
    logic [7:0] onehot;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs for a grant of channel idx (idx < 0 means no grant).
  function automatic exp_t mk(input int idx);
    exp_t e;
    e = '0;
    if (idx >= 0) begin
      e.valid  = 1'b1;
      e.idx    = 8'(idx);
      e.onehot = 8'(1) << idx;
    end
    return e;
  endfunction

  // Reference for fixed priority: index of the highest set bit, -1 if none.
  function automatic int hi_bit(input int r);
    int h;
    h = -1;
    for (int k = 0; k < 8; k++) begin
      if (r[k]) h = k;
    end
    return h;
  endfunction

  // Push the expectation, advance one edge, pop and compare.
  task automatic expect_edge(input bit sel5, input exp_t e, input string tag);
    exp_t x;
    logic [31:0] gv, gi, go;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x  = sb.pop_front();
    gv = sel5 ? 32'(v5)   : 32'(v8);
    gi = sel5 ? 32'(idx5) : 32'(idx8);
    go = sel5 ? 32'(oh5)  : 32'(oh8);
    check({tag, "_valid"},  gv, 32'(x.valid));
    check({tag, "_idx"},    gi, 32'(x.idx));
    check({tag, "_onehot"}, go, 32'(x.onehot));
    $display("[TB] %s: dut%0d valid=%0d idx=%0d onehot=0x%0h", tag, sel5 ? 5 : 8, gv, gi, go);
  endtask

  task automatic do_ack(input bit sel5, input string tag);
    if (sel5) ack5 = 1'b1;
    else      ack8 = 1'b1;
    expect_edge(sel5, mk(-1), {tag, "_ack"});
    ack5 = 1'b0;
    ack8 = 1'b0;
  endtask

  // One complete transaction: drive req/mode, check the grant, ack it.
  task automatic run_txn(input bit sel5, input logic [7:0] r, input logic m,
                         input int exp_idx, input string tag);
    if (sel5) begin
      req5  = r[4:0];
      mode5 = m;
    end else begin
      req8  = r;
      mode8 = m;
    end
    expect_edge(sel5, mk(exp_idx), tag);
    if (exp_idx >= 0) do_ack(sel5, tag);
  endtask

  int rr_seq[6] = '{7, 5, 2, 0, 7, 5};
  int seq5[$];

  initial begin
    rst_n = 1'b0;
    req8  = 8'hFF;
    mode8 = 1'b0;
    ack8  = 1'b0;
    req5  = '0;
    mode5 = 1'b0;
    ack5  = 1'b0;
`ifdef PRIO_ARBITER_REQ_MASK_EN
    mask8 = '0;
    mask5 = 5'b10000;
`endif

    // Reset held with all requests active.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  32'(v8),   32'd0);
    check("rst_idx",    32'(idx8), 32'd0);
    check("rst_onehot", 32'(oh8),  32'd0);
    rst_n = 1'b1;
    expect_edge(1'b0, mk(7), "rst_release");
    do_ack(1'b0, "rst_release");

    // Fixed-priority sweep: registered 8:3 encoder truth table.
    for (int r = 0; r < 256; r++) begin
      run_txn(1'b0, 8'(r), 1'b0, hi_bit(r), $sformatf("fix_%0d", r));
    end

    // Round-robin fairness with bits 7,5,2,0 held.
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, 8'hA5, 1'b1, rr_seq[i], $sformatf("rr_%0d", i));
    end

    // Sticky grant survives its request dropping.
    req8  = 8'h10;
    mode8 = 1'b0;
    expect_edge(1'b0, mk(4), "sticky_grant");
    req8 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      expect_edge(1'b0, mk(4), $sformatf("sticky_hold_%0d", i));
    end
    do_ack(1'b0, "sticky");
    expect_edge(1'b0, mk(-1), "sticky_idle");

    // Ack while idle has no effect.
    ack8 = 1'b1;
    expect_edge(1'b0, mk(-1), "ack_idle");
    ack8 = 1'b0;

    // Asynchronous reset in the middle of a grant (rr_ptr is 5 here).
    req8  = 8'h10;
    mode8 = 1'b1;
    expect_edge(1'b0, mk(4), "arst_grant");
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(v8),   32'd0);
    check("arst_idx",    32'(idx8), 32'd0);
    check("arst_onehot", 32'(oh8),  32'd0);
    req8  = 8'h81;
    mode8 = 1'b1;
    #1 rst_n = 1'b1;
    expect_edge(1'b0, mk(7), "arst_restart");
    do_ack(1'b0, "arst_restart");
    run_txn(1'b0, 8'h81, 1'b1, 0, "arst_rr_next");
    run_txn(1'b0, 8'h81, 1'b1, 7, "arst_rr_wrap");
    req8 = 8'h00;

    // N=5 round-robin wrap.
`ifdef PRIO_ARBITER_REQ_MASK_EN
    seq5 = '{3, 2, 1, 0, 3};
`else
    seq5 = '{4, 3, 2, 1, 0, 4};
`endif
    foreach (seq5[i]) begin
      run_txn(1'b1, 8'h1F, 1'b1, seq5[i], $sformatf("n5_rr_%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_prio_arbiter
